// File: rtl/mv_debounce_array.sv
// Multi-channel button conditioner: 2-FF synchroniser, millisecond stability filter,
// edge pulses, long-press pulse and auto-repeat, all timed from one shared ms prescaler.
module mv_debounce_array #(
    parameter int unsigned   CH          = 4,
    parameter int unsigned   FREQ        = 27,
    parameter int unsigned   DEBOUNCE_MS = 20,
    parameter int unsigned   LONG_MS     = 1000,
    parameter int unsigned   REPEAT_MS   = 200,
    parameter logic [CH-1:0] ACTIVE_LOW  = {CH{1'b0}}
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [CH-1:0]   button_in,
    output logic [CH-1:0]   button_out,
    output logic [CH-1:0]   button_posedge,
    output logic [CH-1:0]   button_negedge,
    output logic [CH-1:0]   button_long,
    output logic [CH-1:0]   button_repeat,
    // Hold FSM state, 2 bits per channel: 0 = IDLE, 1 = PRESS, 2 = HELD
    output logic [2*CH-1:0] dbg_hold_state
);

    localparam int unsigned T  = FREQ * 1000;
    localparam int unsigned PW = (T > 1) ? $clog2(T) : 1;

    localparam logic [7:0]  DB_C = 8'(DEBOUNCE_MS);
    localparam logic [15:0] LG_C = 16'(LONG_MS);
    localparam logic [15:0] RP_C = 16'(REPEAT_MS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRESS = 2'd1,
        ST_HELD  = 2'd2
    } hold_state_t;

    if (CH < 1 || CH > 32 || DEBOUNCE_MS < 1 || DEBOUNCE_MS > 255 ||
        LONG_MS <= DEBOUNCE_MS || LONG_MS > 65535 || REPEAT_MS > 65535) begin : g_bad_params
        $error("mv_debounce_array: parameter out of range");
    end

    // ------------------------------------------------------------------
    // Shared millisecond prescaler
    // ------------------------------------------------------------------
    logic [PW-1:0] pcnt;
    logic          tick;

    assign tick = (pcnt == PW'(T - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt <= '0;
        end else if (tick) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + PW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Per-channel conditioning
    // ------------------------------------------------------------------
    for (genvar i = 0; i < CH; i++) begin : g_ch
        logic        s1;
        logic        s2;
        logic        s3;
        logic [7:0]  scnt;
        logic        out_r;
        logic        pos_r;
        logic        neg_r;

        hold_state_t state;
        hold_state_t state_nxt;
        logic [15:0] hcnt;
        logic [15:0] hcnt_nxt;
        logic [15:0] rcnt;
        logic [15:0] rcnt_nxt;
        logic        long_r;
        logic        long_nxt;
        logic        rep_r;
        logic        rep_nxt;

        // The update also requires s2==s3 so a single-cycle glitch arriving while
        // scnt is still saturated cannot slip through before the filter restarts.
        always_ff @(posedge clk) begin
            if (rst) begin
                s1    <= 1'b0;
                s2    <= 1'b0;
                s3    <= 1'b0;
                scnt  <= '0;
                out_r <= 1'b0;
                pos_r <= 1'b0;
                neg_r <= 1'b0;
            end else begin
                s1    <= button_in[i] ^ ACTIVE_LOW[i];
                s2    <= s1;
                s3    <= s2;
                pos_r <= 1'b0;
                neg_r <= 1'b0;
                if (s2 != s3) begin
                    scnt <= '0;
                end else if (tick && scnt != DB_C) begin
                    scnt <= scnt + 8'd1;
                end
                if (s2 == s3 && scnt == DB_C && s2 != out_r) begin
                    out_r <= s2;
                    pos_r <= s2;
                    neg_r <= ~s2;
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                state  <= ST_IDLE;
                hcnt   <= '0;
                rcnt   <= '0;
                long_r <= 1'b0;
                rep_r  <= 1'b0;
            end else begin
                state  <= state_nxt;
                hcnt   <= hcnt_nxt;
                rcnt   <= rcnt_nxt;
                long_r <= long_nxt;
                rep_r  <= rep_nxt;
            end
        end

        // Release outranks any tick landing in the same cycle.
        always_comb begin
            state_nxt = state;
            hcnt_nxt  = hcnt;
            rcnt_nxt  = rcnt;
            long_nxt  = 1'b0;
            rep_nxt   = 1'b0;
            if (!out_r) begin
                state_nxt = ST_IDLE;
                hcnt_nxt  = '0;
                rcnt_nxt  = '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state_nxt = ST_PRESS;
                        hcnt_nxt  = '0;
                        rcnt_nxt  = '0;
                    end
                    ST_PRESS: begin
                        if (tick) begin
                            hcnt_nxt = hcnt + 16'd1;
                            if (hcnt + 16'd1 == LG_C) begin
                                long_nxt  = 1'b1;
                                rcnt_nxt  = '0;
                                state_nxt = ST_HELD;
                            end
                        end
                    end
                    ST_HELD: begin
                        if (tick && RP_C != 16'd0) begin
                            if (rcnt + 16'd1 == RP_C) begin
                                rep_nxt  = 1'b1;
                                rcnt_nxt = '0;
                            end else begin
                                rcnt_nxt = rcnt + 16'd1;
                            end
                        end
                    end
                    default: begin
                        state_nxt = ST_IDLE;
                        hcnt_nxt  = '0;
                        rcnt_nxt  = '0;
                    end
                endcase
            end
        end

        assign button_out[i]          = out_r;
        assign button_posedge[i]      = pos_r;
        assign button_negedge[i]      = neg_r;
        assign button_long[i]         = long_r;
        assign button_repeat[i]       = rep_r;
        assign dbg_hold_state[2*i +: 2] = state;
    end

endmodule

// File: tb/tb_mv_debounce_array.sv
// Bench for mv_debounce_array: randomized button stimulus, an event-timing reference
// model feeding an expected-pulse queue, and a monitor that checks every pulse and level.
module tb_mv_debounce_array;

    localparam int CH   = 4;
    localparam int FREQ = 1;
    localparam int DB   = 2;
    localparam int LONG = 5;
    localparam int REP  = 3;
    localparam int T    = FREQ * 1000;
    localparam logic [CH-1:0] AL = 4'b1000;
    localparam int EW = 42;

    // ---------------- clock / reset / DUT ----------------
    logic            clk = 1'b0;
    logic            rst;
    logic [CH-1:0]   button_in;
    logic [CH-1:0]   button_out;
    logic [CH-1:0]   button_posedge;
    logic [CH-1:0]   button_negedge;
    logic [CH-1:0]   button_long;
    logic [CH-1:0]   button_repeat;
    logic [2*CH-1:0] dbg_hold_state;

    always #5 clk = ~clk;

    mv_debounce_array #(
        .CH(CH), .FREQ(FREQ), .DEBOUNCE_MS(DB), .LONG_MS(LONG), .REPEAT_MS(REP), .ACTIVE_LOW(AL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .button_in(button_in),
        .button_out(button_out),
        .button_posedge(button_posedge),
        .button_negedge(button_negedge),
        .button_long(button_long),
        .button_repeat(button_repeat),
        .dbg_hold_state(dbg_hold_state)
    );

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [EW-1:0] exp_q[$];

    // Event = {cycle, channel, kind}; kind 0=posedge 1=negedge 2=long 3=repeat
    function automatic logic [EW-1:0] mk_ev(input int c, input int ch, input int k);
        return {32'(c), 8'(ch), 2'(k)};
    endfunction

    // ---------------- reference model ----------------
    // Timing is derived arithmetically: ticks are the edges whose reset-relative index
    // is a multiple of T; the filter passes once DB ticks fall strictly after the last
    // synchronised change; long/repeat edges are computed from the press edge.
    logic [CH-1:0] al_v = AL;
    logic [CH-1:0] m_out_v = '0;
    int n_rel = 0;
    bit samp [CH][3];
    int m_chg [CH];
    int m_press [CH];

    always @(posedge clk) begin
        bit [3:0] fire;
        bit lvl;
        bit prev;
        int qt;
        int first;
        int long_e;
        cyc++;
        if (rst) begin
            n_rel = 0;
            m_out_v = '0;
            for (int i = 0; i < CH; i++) begin
                samp[i][0] = 1'b0;
                samp[i][1] = 1'b0;
                samp[i][2] = 1'b0;
                m_chg[i] = 0;
                m_press[i] = -1;
            end
        end else begin
            n_rel++;
            for (int i = 0; i < CH; i++) begin
                fire = '0;
                lvl = samp[i][1];
                prev = samp[i][2];
                if (m_out_v[i] && m_press[i] >= 0 && (n_rel % T) == 0) begin
                    first = ((m_press[i] + 2 + T - 1) / T) * T;
                    long_e = first + (LONG - 1) * T;
                    if (n_rel == long_e) fire[2] = 1'b1;
                    else if (REP != 0 && n_rel > long_e && ((n_rel - long_e) % (REP * T)) == 0) fire[3] = 1'b1;
                end
                if (lvl != prev) begin
                    m_chg[i] = n_rel;
                end else begin
                    qt = (n_rel - 1) / T - m_chg[i] / T;
                    if (qt >= DB && lvl != m_out_v[i]) begin
                        m_out_v[i] = lvl;
                        if (lvl) begin
                            fire[0] = 1'b1;
                            m_press[i] = n_rel;
                        end else begin
                            fire[1] = 1'b1;
                            m_press[i] = -1;
                        end
                    end
                end
                for (int k = 0; k < 4; k++) if (fire[k]) exp_q.push_back(mk_ev(cyc, i, k));
                samp[i][2] = samp[i][1];
                samp[i][1] = samp[i][0];
                samp[i][0] = button_in[i] ^ al_v[i];
            end
        end
    end

    // ---------------- monitor ----------------
    int last_pos [CH];
    int last_lr [CH];
    bit released [CH];
    int n_long [CH];
    int n_rep [CH];
    bit lat_arm = 1'b0;
    int press_t0 = 0;

    always @(negedge clk) begin
        logic [3:0] pv;
        logic [EW-1:0] ev;
        logic [EW-1:0] want;
        int d;
        while (exp_q.size() > 0 && int'(exp_q[0][41:10]) < cyc) begin
            checks++;
            errors++;
            $display("FAIL missed_pulse: at cycle %0d nothing seen, required ch %0d kind %0d at cycle %0d",
                     cyc, exp_q[0][9:2], exp_q[0][1:0], exp_q[0][41:10]);
            void'(exp_q.pop_front());
        end
        for (int c = 0; c < CH; c++) begin
            pv = {button_repeat[c], button_long[c], button_negedge[c], button_posedge[c]};
            for (int k = 0; k < 4; k++) begin
                if (pv[k]) begin
                    checks++;
                    want = mk_ev(cyc, c, k);
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL spurious_pulse: got ch %0d kind %0d at cycle %0d, required none", c, k, cyc);
                    end else begin
                        ev = exp_q.pop_front();
                        if (ev != want) begin
                            errors++;
                            $display("FAIL pulse_match: got ch %0d kind %0d cycle %0d, required ch %0d kind %0d cycle %0d",
                                     c, k, cyc, ev[9:2], ev[1:0], ev[41:10]);
                        end
                    end
                    if (k == 0) begin
                        last_pos[c] = cyc;
                        released[c] = 1'b0;
                        if (c == 0 && lat_arm) begin
                            lat_arm = 1'b0;
                            d = cyc - press_t0;
                            checks++;
                            if (d < DB * T - T + 3 || d > (DB + 1) * T + 4) begin
                                errors++;
                                $display("FAIL press_latency: got %0d cycles, required %0d..%0d",
                                         d, DB * T - T + 3, (DB + 1) * T + 4);
                            end
                        end
                    end else if (k == 1) begin
                        released[c] = 1'b1;
                    end else if (k == 2) begin
                        n_long[c]++;
                        d = cyc - last_pos[c];
                        checks++;
                        if (d < (LONG - 1) * T || d > (LONG + 1) * T) begin
                            errors++;
                            $display("FAIL long_delay: ch %0d got %0d cycles after posedge, required %0d..%0d",
                                     c, d, (LONG - 1) * T, (LONG + 1) * T);
                        end
                        last_lr[c] = cyc;
                    end else begin
                        n_rep[c]++;
                        d = cyc - last_lr[c];
                        checks++;
                        if (d != REP * T || released[c]) begin
                            errors++;
                            $display("FAIL repeat_period: ch %0d got %0d cycles (released=%0d), required %0d while held",
                                     c, d, released[c], REP * T);
                        end
                        last_lr[c] = cyc;
                    end
                end
            end
        end
        checks++;
        if (button_out !== m_out_v) begin
            errors++;
            $display("FAIL button_out_level: got %b required %b at cycle %0d", button_out, m_out_v, cyc);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_ch(input int ch, input bit pressed);
        logic [CH-1:0] v;
        v = button_in;
        v[ch] = pressed ^ al_v[ch];
        button_in = v;
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if (button_out !== '0 || button_posedge !== '0 || button_negedge !== '0 ||
            button_long !== '0 || button_repeat !== '0 || dbg_hold_state !== '0) begin
            errors++;
            $display("FAIL %s: got out=%b pos=%b neg=%b long=%b rep=%b st=%b, required all zero",
                     name, button_out, button_posedge, button_negedge, button_long, button_repeat, dbg_hold_state);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int l0;
        int r0;
        for (int i = 0; i < CH; i++) begin
            last_pos[i] = 0;
            last_lr[i] = 0;
            released[i] = 1'b0;
            n_long[i] = 0;
            n_rep[i] = 0;
        end
        rst = 1'b1;
        button_in = 4'hF;
        idle(5);
        check_all_zero("reset_state");
        button_in = AL;
        rst = 1'b0;
        idle(2500 + $urandom_range(0, 300));

        // clean press on ch0
        press_t0 = cyc;
        lat_arm = 1'b1;
        set_ch(0, 1'b1);
        idle(3200 + $urandom_range(0, 400));
        set_ch(0, 1'b0);
        idle(3200);

        // bouncing ch1, then a clean hold
        for (int k = 0; k < 17; k++) begin
            set_ch(1, (k % 2) == 0);
            idle(300);
        end
        set_ch(1, 1'b1);
        idle(3500);
        set_ch(1, 1'b0);
        idle(3000);

        // long press and repeats on ch2
        l0 = n_long[2];
        r0 = n_rep[2];
        set_ch(2, 1'b1);
        idle(12000);
        set_ch(2, 1'b0);
        idle(3000);
        checks++;
        if (n_long[2] - l0 != 1 || n_rep[2] - r0 < 2) begin
            errors++;
            $display("FAIL long_repeat_count: got long=%0d rep=%0d, required long=1 rep>=2",
                     n_long[2] - l0, n_rep[2] - r0);
        end

        // active-low ch3
        set_ch(3, 1'b1);
        idle(3500);
        set_ch(3, 1'b0);
        idle(3000);

        // reset while ch2 is held past long press
        set_ch(2, 1'b1);
        idle(9000);
        rst = 1'b1;
        idle(1);
        check_all_zero("reset_mid_hold");
        rst = 1'b0;
        l0 = n_long[2];
        idle(9000);
        checks++;
        if (n_long[2] - l0 != 1) begin
            errors++;
            $display("FAIL long_after_reset: got %0d long pulses, required 1", n_long[2] - l0);
        end
        set_ch(2, 1'b0);
        idle(3000);

        // random multi-channel activity
        for (int it = 0; it < 6; it++) begin
            for (int c = 0; c < CH; c++) set_ch(c, 1'($urandom_range(0, 1)));
            idle($urandom_range(100, 2200));
        end
        for (int c = 0; c < CH; c++) set_ch(c, 1'b0);
        idle(3000);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: got %0d pending expected pulses, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
